// File: rtl/pmp_access_gate.sv
// pmp_access_gate: single-outstanding load/store gate in front of data memory.
// Each request is checked against the combinational PMP checker. Granted
// requests go to memory over valid/ready, and denied ones return as faults.
// Every fault is recorded in the trap-info registers (addr/cause/count).
// Optional macro PMP_ACCESS_GATE_TIMEOUT_EN adds a memory-response timeout
// (MEM_TIMEOUT cycles) that faults with cause 2'b11.
module pmp_access_gate #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_rd,
   input  logic              req_wr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic [ADDR_W-1:0] pmp_addr,
   output logic              pmp_rd,
   output logic              pmp_wr,
   input  logic              pmp_granted,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_fault,
   output logic              fault_pending,
   output logic [ADDR_W-1:0] fault_addr,
   output logic [1:0]        fault_cause,
   input  logic              fault_clr,
   output logic [7:0]        fault_count
);

   if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > 255) begin : g_bad_timeout
      $error("pmp_access_gate: MEM_TIMEOUT must be in 1..255");
   end

   typedef enum logic [1:0] {IDLE, CHECK, MEM, RESP} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              rd_q, rd_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rsp_fault_q, rsp_fault_d;
   logic              fault_pending_q, fault_pending_d;
   logic [ADDR_W-1:0] fault_addr_q, fault_addr_d;
   logic [1:0]        fault_cause_q, fault_cause_d;
   logic [7:0]        fault_count_q, fault_count_d;
   logic              new_fault;
   logic [1:0]        new_cause;
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);
   logic [7:0]        tmo_q, tmo_d;
`endif

   // Request sequencing: latch in IDLE, check, access memory, hold response.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      rsp_fault_d = rsp_fault_q;
      new_fault   = 1'b0;
      new_cause   = 2'b00;
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
      tmo_d       = tmo_q;
`endif
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               addr_d      = req_addr;
               rd_d        = req_rd;
               wr_d        = req_wr;
               wdata_d     = req_wdata;
               rdata_d     = '0;
               rsp_fault_d = 1'b0;
               // An access with neither rd nor wr is a no-op: answer directly.
               state_d     = (req_rd | req_wr) ? CHECK : RESP;
            end
         end
         CHECK: begin
            if (pmp_granted) begin
               state_d = MEM;
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
               tmo_d   = '0;
`endif
            end else begin
               state_d     = RESP;
               rsp_fault_d = 1'b1;
               new_fault   = 1'b1;
               new_cause   = wr_q ? 2'b10 : 2'b01;
            end
         end
         MEM: begin
            if (mem_ready) begin
               // rd&wr is performed as a write, so only pure reads return data.
               rdata_d = (rd_q & ~wr_q) ? mem_rdata : '0;
               state_d = RESP;
            end
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               state_d     = RESP;
               rsp_fault_d = 1'b1;
               new_fault   = 1'b1;
               new_cause   = 2'b11;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
`endif
         end
         RESP: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Trap info: a fault raised this cycle wins over a simultaneous clear.
   always_comb begin
      fault_pending_d = fault_pending_q;
      fault_addr_d    = fault_addr_q;
      fault_cause_d   = fault_cause_q;
      fault_count_d   = fault_count_q;
      if (new_fault) begin
         fault_pending_d = 1'b1;
         fault_addr_d    = addr_q;
         fault_cause_d   = new_cause;
         if (fault_clr)                 fault_count_d = 8'd1;
         else if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
      end else if (fault_clr) begin
         fault_pending_d = 1'b0;
         fault_count_d   = 8'd0;
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= IDLE;
         addr_q          <= '0;
         rd_q            <= 1'b0;
         wr_q            <= 1'b0;
         wdata_q         <= '0;
         rdata_q         <= '0;
         rsp_fault_q     <= 1'b0;
         fault_pending_q <= 1'b0;
         fault_addr_q    <= '0;
         fault_cause_q   <= 2'b00;
         fault_count_q   <= 8'd0;
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
         tmo_q           <= 8'd0;
`endif
      end else begin
         state_q         <= state_d;
         addr_q          <= addr_d;
         rd_q            <= rd_d;
         wr_q            <= wr_d;
         wdata_q         <= wdata_d;
         rdata_q         <= rdata_d;
         rsp_fault_q     <= rsp_fault_d;
         fault_pending_q <= fault_pending_d;
         fault_addr_q    <= fault_addr_d;
         fault_cause_q   <= fault_cause_d;
         fault_count_q   <= fault_count_d;
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
         tmo_q           <= tmo_d;
`endif
      end
   end

   // Outputs decode directly from state so reset drops valids asynchronously.
   always_comb begin
      req_ready     = (state_q == IDLE);
      pmp_addr      = addr_q;
      pmp_rd        = (state_q == CHECK) & rd_q;
      pmp_wr        = (state_q == CHECK) & wr_q;
      mem_valid     = (state_q == MEM);
      mem_addr      = addr_q;
      mem_we        = wr_q;
      mem_wdata     = wdata_q;
      rsp_valid     = (state_q == RESP);
      rsp_rdata     = rdata_q;
      rsp_fault     = rsp_fault_q;
      fault_pending = fault_pending_q;
      fault_addr    = fault_addr_q;
      fault_cause   = fault_cause_q;
      fault_count   = fault_count_q;
   end

endmodule

// File: tb/tb_pmp_access_gate.sv
// Directed + randomized bench for pmp_access_gate with a transaction-level model.
module tb_pmp_access_gate;
   localparam int TMO = 4;
`ifdef PMP_ACCESS_GATE_TIMEOUT_EN
   localparam bit TMO_EN = 1'b1;
`else
   localparam bit TMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0, req_rd = 1'b0, req_wr = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        req_ready;
   logic [7:0]  pmp_addr;
   logic        pmp_rd, pmp_wr, pmp_granted;
   logic        mem_valid, mem_we;
   logic        mem_ready = 1'b0;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        rsp_valid, rsp_fault;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        fault_pending;
   logic [7:0]  fault_addr, fault_count;
   logic [1:0]  fault_cause;
   logic        fault_clr = 1'b0;

   // environment: permission tables and bench-side memory
   logic        perm_r [256];
   logic        perm_w [256];
   logic [31:0] bmem [256];
   // reference model state
   logic [31:0] ref_mem [256];
   logic        m_pend;
   logic [7:0]  m_addr, m_cnt;
   logic [1:0]  m_cause;

   int errs = 0;
   int checks = 0;

   always #5 clk = ~clk;

   assign pmp_granted = (!pmp_rd || perm_r[pmp_addr]) && (!pmp_wr || perm_w[pmp_addr]);

   pmp_access_gate #(.ADDR_W(8), .DATA_W(32), .MEM_TIMEOUT(TMO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_rd(req_rd), .req_wr(req_wr), .req_wdata(req_wdata),
      .pmp_addr(pmp_addr), .pmp_rd(pmp_rd), .pmp_wr(pmp_wr), .pmp_granted(pmp_granted),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_we(mem_we),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
      .fault_pending(fault_pending), .fault_addr(fault_addr), .fault_cause(fault_cause),
      .fault_clr(fault_clr), .fault_count(fault_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_trap();
      chk("fault_pending", {31'd0, fault_pending}, {31'd0, m_pend});
      chk("fault_count", {24'd0, fault_count}, {24'd0, m_cnt});
      chk("fault_addr", {24'd0, fault_addr}, {24'd0, m_addr});
      chk("fault_cause", {30'd0, fault_cause}, {30'd0, m_cause});
   endtask

   // One full transaction; lat = extra mem_valid cycles before mem_ready,
   // rlat = cycles rsp_ready is withheld, clr = pulse fault_clr in cycle N+1.
   task automatic run_req(input logic [7:0] a, input logic rd, input logic wr,
                          input logic [31:0] wd, input int lat, input int rlat, input bit clr);
      bit acc, gr, to, exp_fault;
      int exp_lat, exp_mvc, cyc, mvc;
      logic [31:0] exp_rdata;
      // model: outcome from permission rules and memory contents
      acc       = rd | wr;
      gr        = acc && (!rd || perm_r[a]) && (!wr || perm_w[a]);
      to        = gr && TMO_EN && (lat >= TMO);
      exp_fault = (acc && !gr) || to;
      exp_lat   = !acc ? 1 : (!gr ? 2 : (to ? 2 + TMO : 3 + lat));
      exp_mvc   = !gr ? 0 : (to ? TMO : lat + 1);
      exp_rdata = (gr && !to && rd && !wr) ? ref_mem[a] : 32'd0;
      if (gr && !to && wr) ref_mem[a] = wd;
      if (exp_fault) begin
         m_pend  = 1'b1;
         m_addr  = a;
         m_cause = to ? 2'b11 : (wr ? 2'b10 : 2'b01);
         m_cnt   = clr ? 8'd1 : (m_cnt == 8'd255 ? 8'd255 : m_cnt + 8'd1);
      end else if (clr) begin
         m_pend = 1'b0;
         m_cnt  = 8'd0;
      end

      @(negedge clk);
      chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
      req_valid = 1'b1; req_addr = a; req_rd = rd; req_wr = wr; req_wdata = wd;
      @(negedge clk);
      req_valid = 1'b0; req_addr = 8'($urandom); req_wdata = $urandom;
      req_rd = 1'($urandom); req_wr = 1'($urandom);
      if (clr) fault_clr = 1'b1;
      cyc = 1; mvc = 0;
      if (acc) begin
         chk("pmp_addr", {24'd0, pmp_addr}, {24'd0, a});
         chk("pmp_rd", {31'd0, pmp_rd}, {31'd0, rd});
         chk("pmp_wr", {31'd0, pmp_wr}, {31'd0, wr});
      end
      while (!rsp_valid && cyc < 100) begin
         mem_ready = 1'b0;
         if (mem_valid) begin
            chk("mem_addr", {24'd0, mem_addr}, {24'd0, a});
            chk("mem_we", {31'd0, mem_we}, {31'd0, wr});
            if (mvc == lat) begin
               mem_ready = 1'b1;
               mem_rdata = bmem[mem_addr];
               if (mem_we) bmem[mem_addr] = mem_wdata;
            end else begin
               mem_rdata = $urandom;
            end
            mvc++;
         end
         @(negedge clk);
         fault_clr = 1'b0; mem_ready = 1'b0;
         cyc++;
      end
      chk("rsp_seen", {31'd0, rsp_valid}, 32'd1);
      chk("latency", cyc, exp_lat);
      chk("mem_valid_cycles", mvc, exp_mvc);
      chk("rsp_rdata", rsp_rdata, exp_rdata);
      chk("rsp_fault", {31'd0, rsp_fault}, {31'd0, exp_fault});
      for (int i = 0; i < rlat; i++) begin
         @(negedge clk);
         fault_clr = 1'b0;
         chk("rsp_hold_valid", {31'd0, rsp_valid}, 32'd1);
         chk("rsp_hold_rdata", rsp_rdata, exp_rdata);
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0; fault_clr = 1'b0;
      chk("rsp_done_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rsp_done_ready", {31'd0, req_ready}, 32'd1);
      chk_trap();
   endtask

   initial begin
      int nmv;
      for (int i = 0; i < 256; i++) begin
         perm_r[i] = 1'($urandom); perm_w[i] = 1'($urandom);
         bmem[i] = $urandom; ref_mem[i] = bmem[i];
      end
      m_pend = 1'b0; m_addr = 8'd0; m_cnt = 8'd0; m_cause = 2'b00;

      // reset values
      #3;
      chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_pmp_rd", {31'd0, pmp_rd}, 32'd0);
      chk_trap();
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // granted read, immediate mem_ready
      perm_r[8'h10] = 1'b1; bmem[8'h10] = 32'hDEADBEEF; ref_mem[8'h10] = 32'hDEADBEEF;
      run_req(8'h10, 1'b1, 1'b0, 32'd0, 0, 0, 1'b0);
      // denied write
      perm_w[8'h50] = 1'b0;
      run_req(8'h50, 1'b0, 1'b1, 32'h1234_5678, 0, 1, 1'b0);
      // denied reads, clear coinciding with the second fault
      perm_r[8'h90] = 1'b0; perm_r[8'h91] = 1'b0;
      run_req(8'h90, 1'b1, 1'b0, 32'd0, 0, 0, 1'b0);
      run_req(8'h91, 1'b1, 1'b0, 32'd0, 0, 0, 1'b1);
      // no-op access, granted rd&wr (performed as write), then read it back
      run_req(8'h22, 1'b0, 1'b0, 32'hFFFF_FFFF, 0, 2, 1'b0);
      perm_r[8'h20] = 1'b1; perm_w[8'h20] = 1'b1;
      run_req(8'h20, 1'b1, 1'b1, 32'hCAFE_F00D, 2, 0, 1'b0);
      run_req(8'h20, 1'b1, 1'b0, 32'd0, 1, 0, 1'b0);

      // saturation then clear
      perm_r[8'h77] = 1'b0;
      for (int i = 0; i < 256; i++) run_req(8'h77, 1'b1, 1'b0, 32'd0, 0, 0, 1'b0);
      @(negedge clk); fault_clr = 1'b1;
      @(negedge clk); fault_clr = 1'b0;
      m_pend = 1'b0; m_cnt = 8'd0;
      chk_trap();

      // slow memory: waits without timeout, faults with cause 11 otherwise
      perm_w[8'h40] = 1'b1;
      run_req(8'h40, 1'b0, 1'b1, 32'h0BAD_CAFE, 20, 0, 1'b0);

      // reset while waiting in MEM
      perm_w[8'h33] = 1'b1;
      @(negedge clk);
      req_valid = 1'b1; req_addr = 8'h33; req_rd = 1'b0; req_wr = 1'b1; req_wdata = 32'h55;
      @(negedge clk); req_valid = 1'b0;
      nmv = 0;
      while (!mem_valid && nmv < 10) begin @(negedge clk); nmv++; end
      chk("pre_rst_mem_valid", {31'd0, mem_valid}, 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_mem_valid", {31'd0, mem_valid}, 32'd0);
      chk("rst_async_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      m_pend = 1'b0; m_addr = 8'd0; m_cnt = 8'd0; m_cause = 2'b00;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_req_ready", {31'd0, req_ready}, 32'd1);
      chk("post_rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk_trap();

      // randomized traffic
      for (int n = 0; n < 80; n++) begin
         run_req(8'($urandom), 1'($urandom), 1'($urandom), $urandom,
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                 ($urandom_range(0, 7) == 0));
      end

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
